program_counter: RTL and testbench

//   Instruction-address register of the RISC-V datapath (RV64 by default).
//   On every rising clock edge it advances by a caller-supplied increment:
//   4 for sequential fetch, or a signed branch/jump offset.
//   Its addr output drives the instruction memory and the PC-relative adders.

---
 rtl/program_counter_pkg.sv | 8 +
 rtl/program_counter_pc_adder.sv | 14 +
 rtl/program_counter.sv | 44 ++++
 tb/tb_program_counter.sv | 121 ++++++++++++
 4 files changed

// File: rtl/program_counter_pkg.sv
// Shared constants for the RV64 program counter and the PC-relative adders.
package program_counter_pkg;

  localparam int unsigned WORDSIZE_DEFAULT   = 64;
  localparam logic [63:0] RESET_ADDR_DEFAULT = 64'h0;
  localparam logic [63:0] PC_STEP            = 64'd4;

endpackage

// File: rtl/program_counter_pc_adder.sv
// WORDSIZE-bit unsigned adder returning {carry, sum}.
// Also used by the branch-target logic.
module pc_adder #(
  parameter int WORDSIZE = 64
) (
  input  logic [WORDSIZE-1:0] a,
  input  logic [WORDSIZE-1:0] b,
  output logic [WORDSIZE-1:0] sum,
  output logic                carry
);

  assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/program_counter.sv
// Instruction-address register: advances by a signed increment every clock.
// Wrap records the carry out of the last update.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int                  WORDSIZE   = WORDSIZE_DEFAULT,
  parameter logic [WORDSIZE-1:0] RESET_ADDR = WORDSIZE'(RESET_ADDR_DEFAULT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WORDSIZE-1:0] increment,
  output logic [WORDSIZE-1:0] addr,
  output logic [WORDSIZE-1:0] next_addr,
  output logic                wrap
);

  // Initialisers give a defined power-up state even before the first reset.
  logic [WORDSIZE-1:0] addr_q = RESET_ADDR;
  logic                wrap_q = 1'b0;
  logic [WORDSIZE-1:0] sum;
  logic                carry;

  pc_adder #(.WORDSIZE(WORDSIZE)) u_adder (
    .a     (addr_q),
    .b     (increment),
    .sum   (sum),
    .carry (carry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= RESET_ADDR;
      wrap_q <= 1'b0;
    end else begin
      addr_q <= sum;
      wrap_q <= carry;
    end
  end

  assign addr      = addr_q;
  assign wrap      = wrap_q;
  assign next_addr = sum;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: stimulus queues expected state,
// a monitor compares it one edge later.
module tb_program_counter;

  localparam int W = 64;

  typedef struct {
    string          name;
    logic [W-1:0]   exp_addr;
    logic           exp_wrap;
  } expect_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] increment = '0;
  logic [W-1:0] addr;
  logic [W-1:0] next_addr;
  logic         wrap;

  expect_t      scoreboard[$];
  int           tests_run = 0;
  int           tests_failed = 0;
  logic [W-1:0] model_addr = '0;

  program_counter #(.WORDSIZE(W), .RESET_ADDR(64'h0)) dut (
    .clk       (clk),
    .reset     (reset),
    .increment (increment),
    .addr      (addr),
    .next_addr (next_addr),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, check next_addr against the bench's own
  // running address, and queue the hand-computed state after the edge.
  task automatic applyStimulus(input string name, input logic rst,
                               input logic [W-1:0] inc,
                               input logic [W-1:0] exp_addr, input logic exp_wrap);
    expect_t e;
    @(negedge clk);
    reset     = rst;
    increment = inc;
    #1;
    checkOutput({name, ".next_addr"}, next_addr, model_addr + inc);
    e.name     = name;
    e.exp_addr = exp_addr;
    e.exp_wrap = exp_wrap;
    scoreboard.push_back(e);
    model_addr = exp_addr;
  endtask

  // Monitor: the DUT presents a new state every edge.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (scoreboard.size() > 0) begin
        e = scoreboard.pop_front();
        checkOutput({e.name, ".addr"}, addr, e.exp_addr);
        checkOutput({e.name, ".wrap"}, {{(W-1){1'b0}}, wrap}, {{(W-1){1'b0}}, e.exp_wrap});
      end
    end
  end

  initial begin
    #1;
    checkOutput("powerup.addr", addr, 64'h0);
    checkOutput("powerup.wrap", {{(W-1){1'b0}}, wrap}, 64'h0);

    for (int i = 1; i <= 6; i++)
      applyStimulus($sformatf("count%0d", i), 1'b0, 64'd1, 64'(i), 1'b0);

    applyStimulus("reset_mid", 1'b1, 64'd1, 64'h0, 1'b0);
    applyStimulus("resume1", 1'b0, 64'd1, 64'h1, 1'b0);
    applyStimulus("resume2", 1'b0, 64'd1, 64'h2, 1'b0);

    applyStimulus("reset_seq", 1'b1, 64'd7, 64'h0, 1'b0);
    applyStimulus("seq1", 1'b0, 64'd4, 64'h4, 1'b0);
    applyStimulus("seq2", 1'b0, 64'd4, 64'h8, 1'b0);
    applyStimulus("seq3", 1'b0, 64'd4, 64'hC, 1'b0);

    applyStimulus("reset_br", 1'b1, 64'd0, 64'h0, 1'b0);
    applyStimulus("jump100", 1'b0, 64'h100, 64'h100, 1'b0);
    applyStimulus("back8", 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'hF8, 1'b1);

    applyStimulus("reset_wrap", 1'b1, 64'd3, 64'h0, 1'b0);
    applyStimulus("to_max", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    applyStimulus("wrap0", 1'b0, 64'd1, 64'h0, 1'b1);
    applyStimulus("after_wrap", 1'b0, 64'd1, 64'h1, 1'b0);

    for (int i = 1; i <= 3; i++)
      applyStimulus($sformatf("stall%0d", i), 1'b0, 64'd0, 64'h1, 1'b0);
    applyStimulus("reset_prio", 1'b1, 64'd5, 64'h0, 1'b0);

    // Let the monitor drain the queue, bounded.
    for (int i = 0; i < 10 && scoreboard.size() > 0; i++)
      @(posedge clk);
    #2;
    if (scoreboard.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", scoreboard.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
